// File: rtl/run_ctrl_pkg.sv
// Shared types and default configuration for the run controller.
// The state encoding is fixed here so the top and any debug tooling agree on it.
package run_ctrl_pkg;

  localparam int unsigned RST_CYCLES_DEF = 2;
  localparam int unsigned MAX_CYCLES_DEF = 4095;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned RST_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CRST = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Used for the RUN-cycle count of the run controller.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) for all flop state so every register samples pre-edge values.
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences core reset, a budgeted run window and a done/req
// four-phase handshake. All outputs are decoded from registered state.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             core_done,
  output logic             core_reset,
  output logic             core_run,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CRST = ST_CRST;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_FIN  = ST_FIN;

  localparam logic [RST_CNT_W-1:0] RST_LOAD = RST_CNT_W'(RST_CYCLES);

  // Budget fires on the edge where the count becomes MAX_CYCLES, i.e. while it still reads MAX_CYCLES-1.
  localparam int unsigned      LAST_RUN_I = (MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1;
  localparam logic [CNT_W-1:0] LAST_RUN   = CNT_W'(LAST_RUN_I);

  if ((RST_CYCLES < 1) || (RST_CYCLES > 15)) begin : g_bad_rst_cycles
    $error("run_ctrl: RST_CYCLES must be in 1..15");
  end
  if (64'(MAX_CYCLES) > ((64'(1) << CNT_W) - 64'(1))) begin : g_bad_max_cycles
    $error("run_ctrl: MAX_CYCLES exceeds the cycle_count range");
  end

  logic [1:0]           state;
  logic [RST_CNT_W-1:0] rst_cnt;
  logic                 start;
  logic                 run_en;
  logic                 budget_hit;

  assign start      = (state == S_IDLE) && req;
  assign run_en     = (state == S_RUN);
  assign budget_hit = (MAX_CYCLES != 0) && (cycle_count == LAST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rst_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state   <= S_CRST;
            rst_cnt <= RST_LOAD;
            timeout <= 1'b0;
          end
        end
        S_CRST: begin
          if (rst_cnt == RST_CNT_W'(1)) begin
            state <= S_RUN;
          end else begin
            rst_cnt <= rst_cnt - RST_CNT_W'(1);
          end
        end
        S_RUN: begin
          // A program finishing on its last budgeted cycle is a clean finish, not a timeout.
          if (core_done) begin
            state   <= S_FIN;
            timeout <= 1'b0;
          end else if (budget_hit) begin
            state   <= S_FIN;
            timeout <= 1'b1;
          end
        end
        S_FIN: begin
          if (!req) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .enable(run_en),
    .count (cycle_count)
  );

  // FIN releases core_reset so the halted core's state can be inspected.
  assign core_reset = (state == S_IDLE) || (state == S_CRST);
  assign core_run   = (state == S_RUN);
  assign busy       = (state == S_CRST) || (state == S_RUN);
  assign done       = (state == S_FIN);

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: three configurations checked every cycle against a
// run-phase model, plus directed scenarios with literal expectations.
module tb_run_ctrl;

  localparam int RSTC = 2;

  typedef struct {
    bit active;
    bit fin;
    int age;
    int cnt;
    bit tmo;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, req, cdone;
  logic [2:0]  core_reset, core_run, busy, done, tmo;
  logic [15:0] cc0, cc1;
  logic [3:0]  cc2;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;
  int n, k;

  mdl_t m0, m1, m2;

  run_ctrl u0 (
    .clk(clk), .reset(rst[0]), .req(req[0]), .core_done(cdone[0]),
    .core_reset(core_reset[0]), .core_run(core_run[0]), .busy(busy[0]),
    .done(done[0]), .timeout(tmo[0]), .cycle_count(cc0)
  );

  run_ctrl #(.MAX_CYCLES(10)) u1 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .core_done(cdone[1]),
    .core_reset(core_reset[1]), .core_run(core_run[1]), .busy(busy[1]),
    .done(done[1]), .timeout(tmo[1]), .cycle_count(cc1)
  );

  run_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) u2 (
    .clk(clk), .reset(rst[2]), .req(req[2]), .core_done(cdone[2]),
    .core_reset(core_reset[2]), .core_run(core_run[2]), .busy(busy[2]),
    .done(done[2]), .timeout(tmo[2]), .cycle_count(cc2)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a run is "active" from acceptance until it ends; the first RSTC
  // cycles of its age are core reset, every later cycle is a counted run cycle.
  function automatic mdl_t step(mdl_t m, logic r, logic q, logic d, int maxc, int satv);
    mdl_t nx = m;
    int   rn;
    if (r) begin
      nx = '{default: 0};
    end else if (m.fin) begin
      if (!q) nx.fin = 1'b0;
    end else if (!m.active) begin
      if (q) begin
        nx.active = 1'b1;
        nx.age    = 0;
        nx.cnt    = 0;
        nx.tmo    = 1'b0;
      end
    end else if (m.age < RSTC) begin
      nx.age = m.age + 1;
    end else begin
      nx.age = m.age + 1;
      rn     = nx.age - RSTC;
      nx.cnt = (rn > satv) ? satv : rn;
      if (d) begin
        nx.active = 1'b0;
        nx.fin    = 1'b1;
        nx.tmo    = 1'b0;
      end else if ((maxc != 0) && (rn == maxc)) begin
        nx.active = 1'b0;
        nx.fin    = 1'b1;
        nx.tmo    = 1'b1;
      end
    end
    return nx;
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, rst[0], req[0], cdone[0], 4095, 65535);
    m1 <= step(m1, rst[1], req[1], cdone[1], 10, 65535);
    m2 <= step(m2, rst[2], req[2], cdone[2], 0, 15);
  end

  task automatic cmp(string u, mdl_t m, logic cr, logic rn, logic b, logic d,
                     logic t, logic [31:0] cc);
    bit erun;
    erun = m.active && (m.age >= RSTC);
    check({u, ".core_reset"}, 32'(cr), 32'(!m.fin && !erun));
    check({u, ".core_run"},   32'(rn), 32'(erun));
    check({u, ".busy"},       32'(b),  32'(m.active));
    check({u, ".done"},       32'(d),  32'(m.fin));
    check({u, ".timeout"},    32'(t),  32'(m.tmo));
    check({u, ".cycle_count"}, cc, 32'(m.cnt));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("u0", m0, core_reset[0], core_run[0], busy[0], done[0], tmo[0], {16'b0, cc0});
      cmp("u1", m1, core_reset[1], core_run[1], busy[1], done[1], tmo[1], {16'b0, cc1});
      cmp("u2", m2, core_reset[2], core_run[2], busy[2], done[2], tmo[2], {28'b0, cc2});
    end
  end

  task automatic cyc(int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  // Returns at the start of RUN cycle 1; crst counts core-reset cycles seen.
  task automatic wait_run(int i, output int crst);
    crst = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (core_run[i]) return;
      if (core_reset[i] && busy[i]) crst++;
    end
    check("wait_run_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_done(int i, output int cycles);
    cycles = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      cycles++;
      if (done[i]) return;
    end
    check("wait_done_expired", 32'd0, 32'd1);
  endtask

  initial begin
    rst   = 3'b111;
    req   = 3'b000;
    cdone = 3'b000;
    cyc(2);
    rst    = 3'b000;
    cmp_en = 1'b1;
    cyc(1);
    check("reset_core_reset", 32'(core_reset[0]), 32'd1);
    check("reset_busy", 32'(busy[0]), 32'd0);
    check("reset_count", 32'(cc0), 32'd0);

    // Normal run ending on RUN cycle 5.
    req[0] = 1'b1;
    wait_run(0, n);
    check("crst_length", 32'(n), 32'd2);
    cyc(4);
    cdone[0] = 1'b1;
    cyc(1);
    check("run5_done", 32'(done[0]), 32'd1);
    check("run5_count", 32'(cc0), 32'd5);
    check("run5_timeout", 32'(tmo[0]), 32'd0);
    check("run5_core_run", 32'(core_run[0]), 32'd0);

    // req held high after done: no new run until req falls.
    cdone[0] = 1'b0;
    cyc(5);
    check("hold_done", 32'(done[0]), 32'd1);
    check("hold_busy", 32'(busy[0]), 32'd0);
    req[0] = 1'b0;
    cyc(1);
    check("release_done", 32'(done[0]), 32'd0);
    check("release_count_kept", 32'(cc0), 32'd5);

    // Stale core_done in IDLE and CRST must not end the run.
    cdone[0] = 1'b1;
    cyc(2);
    req[0] = 1'b1;
    wait_run(0, n);
    check("rerun_count_cleared", 32'(cc0), 32'd0);
    cdone[0] = 1'b0;
    cyc(2);
    cdone[0] = 1'b1;
    cyc(1);
    check("stale_done", 32'(done[0]), 32'd1);
    check("stale_count", 32'(cc0), 32'd3);

    // Reset mid-run wins over req and core_done.
    cdone[0] = 1'b0;
    req[0]   = 1'b0;
    cyc(1);
    req[0] = 1'b1;
    wait_run(0, n);
    cyc(2);
    rst[0]   = 1'b1;
    cdone[0] = 1'b1;
    cyc(1);
    check("midrst_core_reset", 32'(core_reset[0]), 32'd1);
    check("midrst_core_run", 32'(core_run[0]), 32'd0);
    check("midrst_count", 32'(cc0), 32'd0);
    check("midrst_done", 32'(done[0]), 32'd0);
    rst[0]   = 1'b0;
    req[0]   = 1'b0;
    cdone[0] = 1'b0;
    cyc(2);

    // Timeout after exactly 10 RUN cycles.
    req[1] = 1'b1;
    wait_run(1, n);
    wait_done(1, k);
    check("tmo_cycles", 32'(k), 32'd10);
    check("tmo_timeout", 32'(tmo[1]), 32'd1);
    check("tmo_count", 32'(cc1), 32'd10);
    check("tmo_core_run", 32'(core_run[1]), 32'd0);

    // core_done on the last budgeted cycle beats the timeout.
    req[1] = 1'b0;
    cyc(1);
    req[1] = 1'b1;
    wait_run(1, n);
    cyc(9);
    cdone[1] = 1'b1;
    cyc(1);
    check("tie_done", 32'(done[1]), 32'd1);
    check("tie_timeout", 32'(tmo[1]), 32'd0);
    check("tie_count", 32'(cc1), 32'd10);
    cdone[1] = 1'b0;
    req[1]   = 1'b0;
    cyc(1);

    // Saturation with timeout disabled; req dropped mid-run is ignored.
    req[2] = 1'b1;
    wait_run(2, n);
    req[2] = 1'b0;
    cyc(20);
    check("sat_count", 32'(cc2), 32'd15);
    check("sat_busy", 32'(busy[2]), 32'd1);
    cdone[2] = 1'b1;
    cyc(1);
    check("sat_done", 32'(done[2]), 32'd1);
    check("sat_timeout", 32'(tmo[2]), 32'd0);
    cdone[2] = 1'b0;
    cyc(1);
    check("sat_idle_done", 32'(done[2]), 32'd0);
    check("sat_idle_count", 32'(cc2), 32'd15);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
